// File: rtl/neuron_spi_ctrl.sv
// Serial front-end for the grid neuron array: loads per-channel shadow registers over a
// 4-wire port, fires a timed trig pulse, captures dout_i and returns it on miso.
module neuron_spi_ctrl #(
  parameter int N_CH     = 1,
  parameter int DATA_W   = 8,
  parameter int TRIG_LEN = 4,
  parameter int CAP_DLY  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sck,
  input  logic                     cs_n,
  input  logic                     mosi,
  output logic                     miso,
  output logic [N_CH*DATA_W-1:0]   din,
  output logic [N_CH*DATA_W-1:0]   win,
  output logic [N_CH*DATA_W-1:0]   bias,
  output logic [N_CH-1:0]          sign,
  output logic                     trig,
  input  logic [N_CH*DATA_W-1:0]   dout_i,
  output logic                     busy
);

  localparam int REC_W  = 3*DATA_W + 1;
  localparam int PAY_W  = N_CH*REC_W;
  localparam int RD_W   = N_CH*DATA_W;
  localparam int PCNT_W = $clog2(PAY_W + 1);
  localparam int TCNT_W = $clog2(CAP_DLY + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_READ    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  logic [2:0]        sck_sync_q, sck_sync_d;
  logic [2:0]        cs_sync_q, cs_sync_d;
  logic [1:0]        mosi_sync_q, mosi_sync_d;
  state_e            state_q, state_d;
  logic [6:0]        cmd_sh_q, cmd_sh_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              trig_req_q, trig_req_d;
  logic [PAY_W-1:0]  pay_sh_q, pay_sh_d;
  logic [PCNT_W-1:0] pay_cnt_q, pay_cnt_d;
  logic              pay_ovf_q, pay_ovf_d;
  logic [RD_W-1:0]   rd_sh_q, rd_sh_d;
  logic [PAY_W-1:0]  shadow_q, shadow_d;
  logic [RD_W-1:0]   cap_q, cap_d;
  logic              trig_q, trig_d;
  logic              busy_q, busy_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              miso_q, miso_d;

  logic       sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s, cs_low_s, mosi_bit_s;
  logic [7:0] cmd_s;
  logic       commit_ok_s;

  assign sck_rise_s  = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall_s  = ~sck_sync_q[1] & sck_sync_q[2];
  assign cs_rise_s   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall_s   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_low_s    = ~cs_sync_q[1];
  assign mosi_bit_s  = mosi_sync_q[1];
  assign cmd_s       = {cmd_sh_q, mosi_bit_s};
  assign commit_ok_s = (state_q == ST_PAYLOAD) && (pay_cnt_q == PCNT_W'(PAY_W)) && !pay_ovf_q;

  // Next-state logic for the frame FSM, shift paths, shadows and the trig/capture timer.
  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], sck};
    cs_sync_d   = {cs_sync_q[1:0], cs_n};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    state_d     = state_q;
    cmd_sh_d    = cmd_sh_q;
    bit_cnt_d   = bit_cnt_q;
    trig_req_d  = trig_req_q;
    pay_sh_d    = pay_sh_q;
    pay_cnt_d   = pay_cnt_q;
    pay_ovf_d   = pay_ovf_q;
    rd_sh_d     = rd_sh_q;
    shadow_d    = shadow_q;
    cap_d       = cap_q;
    trig_d      = trig_q;
    busy_d      = busy_q;
    tcnt_d      = tcnt_q;
    miso_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_d    = ST_CMD;
          bit_cnt_d  = 3'd0;
          trig_req_d = 1'b0;
          pay_cnt_d  = {PCNT_W{1'b0}};
          pay_ovf_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (sck_rise_s) begin
          cmd_sh_d  = cmd_s[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            case (cmd_s)
              8'h01: state_d = ST_PAYLOAD;
              8'h03: begin
                state_d = ST_READ;
                rd_sh_d = cap_q;
              end
              8'h02: begin
                state_d    = ST_DRAIN;
                trig_req_d = 1'b1;
              end
              default: state_d = ST_DRAIN;
            endcase
          end else begin
            state_d = ST_CMD;
          end
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_PAYLOAD: begin
        // Counter saturates at PAY_W; any further bit marks the frame as overlong.
        if (sck_rise_s) begin
          if (pay_cnt_q == PCNT_W'(PAY_W)) begin
            pay_ovf_d = 1'b1;
          end else begin
            pay_sh_d  = {pay_sh_q[PAY_W-2:0], mosi_bit_s};
            pay_cnt_d = pay_cnt_q + PCNT_W'(1);
          end
        end else begin
          pay_ovf_d = pay_ovf_q;
        end
      end
      ST_READ: begin
        if (sck_fall_s) begin
          rd_sh_d = rd_sh_q << 1;
        end else begin
          rd_sh_d = rd_sh_q;
        end
      end
      ST_DRAIN: state_d = ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase

    if (cs_rise_s) begin
      state_d = ST_IDLE;
      if (commit_ok_s) begin
        shadow_d = pay_sh_q;
      end else begin
        shadow_d = shadow_q;
      end
    end else begin
      shadow_d = shadow_q;
    end

    if (busy_q) begin
      tcnt_d = tcnt_q + TCNT_W'(1);
      trig_d = (tcnt_q < TCNT_W'(TRIG_LEN - 1));
      if (tcnt_q == TCNT_W'(CAP_DLY)) begin
        cap_d  = dout_i;
        busy_d = 1'b0;
        trig_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else if (cs_rise_s && (state_q == ST_DRAIN) && trig_req_q) begin
      trig_d = 1'b1;
      busy_d = 1'b1;
      tcnt_d = {TCNT_W{1'b0}};
    end else begin
      trig_d = 1'b0;
      busy_d = 1'b0;
    end

    if ((state_d == ST_READ) && cs_low_s) begin
      miso_d = rd_sh_d[RD_W-1];
    end else begin
      miso_d = 1'b0;
    end
  end

  // Pad synchronisers; pure pipelines, so they keep tracking the pins through reset.
  always_ff @(posedge clk) begin
    sck_sync_q  <= sck_sync_d;
    cs_sync_q   <= cs_sync_d;
    mosi_sync_q <= mosi_sync_d;
  end

  // Control and data state with synchronous reset; reset aborts any frame or pulse in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_sh_q   <= 7'd0;
      bit_cnt_q  <= 3'd0;
      trig_req_q <= 1'b0;
      pay_sh_q   <= {PAY_W{1'b0}};
      pay_cnt_q  <= {PCNT_W{1'b0}};
      pay_ovf_q  <= 1'b0;
      rd_sh_q    <= {RD_W{1'b0}};
      shadow_q   <= {PAY_W{1'b0}};
      cap_q      <= {RD_W{1'b0}};
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      tcnt_q     <= {TCNT_W{1'b0}};
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_sh_q   <= cmd_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      trig_req_q <= trig_req_d;
      pay_sh_q   <= pay_sh_d;
      pay_cnt_q  <= pay_cnt_d;
      pay_ovf_q  <= pay_ovf_d;
      rd_sh_q    <= rd_sh_d;
      shadow_q   <= shadow_d;
      cap_q      <= cap_d;
      trig_q     <= trig_d;
      busy_q     <= busy_d;
      tcnt_q     <= tcnt_d;
      miso_q     <= miso_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign din[g*DATA_W +: DATA_W]  = shadow_q[g*REC_W +: DATA_W];
    assign win[g*DATA_W +: DATA_W]  = shadow_q[g*REC_W + DATA_W +: DATA_W];
    assign bias[g*DATA_W +: DATA_W] = shadow_q[g*REC_W + 2*DATA_W +: DATA_W];
    assign sign[g]                  = shadow_q[g*REC_W + 3*DATA_W];
  end

  assign trig = trig_q;
  assign busy = busy_q;
  assign miso = miso_q;

endmodule

// File: tb/tb_neuron_spi_ctrl.sv
// Randomised frame-level bench for neuron_spi_ctrl, checked against a transaction model.
`timescale 1ns/1ps
module tb_neuron_spi_ctrl;
  localparam int DW = 8;
  localparam int PAY_W = 25;
  localparam int TRIG_LEN = 4;
  localparam int CAP_DLY = 16;
  localparam int HALF = 60;

  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [DW-1:0] dout_i = 8'd0;
  logic miso, trig, busy, miso_b, trig_b, busy_b;
  logic [DW-1:0] din, win, bias, din_b, win_b, bias_b;
  logic [0:0] sign, sign_b;

  int n_cmp = 0, n_err = 0;
  logic [PAY_W-1:0] sh_exp = 25'd0;
  logic [DW-1:0] cap_exp = 8'd0;
  int trig_exp = 0, trig_seen = 0, trig_b_exp = 0, trig_b_seen = 0;
  int cyc = 0, rise_cyc = 0, pulse_len = 0, busy_len = 0;
  logic trig_prev = 1'b0, busy_prev = 1'b0, trig_b_prev = 1'b0, mon_kill = 1'b0;

  neuron_spi_ctrl #(.N_CH(1), .DATA_W(DW), .TRIG_LEN(TRIG_LEN), .CAP_DLY(CAP_DLY)) u_dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .din(din), .win(win), .bias(bias), .sign(sign), .trig(trig), .dout_i(dout_i), .busy(busy));

  // Same port traffic into a long-capture instance, so a second TRIG lands while busy.
  neuron_spi_ctrl #(.N_CH(1), .DATA_W(DW), .TRIG_LEN(TRIG_LEN), .CAP_DLY(200)) u_dut_long (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso_b),
    .din(din_b), .win(win_b), .bias(bias_b), .sign(sign_b), .trig(trig_b), .dout_i(dout_i), .busy(busy_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] grid_val(input int c);
    return 8'(c * 37 + 11);
  endfunction

  // Pulse/busy timing monitor; also drives a per-cycle dout_i so capture timing is observable.
  always @(negedge clk) begin
    if (mon_kill) begin
      pulse_len = 0;
      busy_len = 0;
    end else begin
      if (trig && !trig_prev) begin
        trig_seen++;
        rise_cyc = cyc;
        pulse_len = 0;
      end
      if (trig) pulse_len++;
      else if (trig_prev) chk("trig_len", 32'(pulse_len), 32'(TRIG_LEN));
      if (busy) begin
        if (!busy_prev) busy_len = 0;
        busy_len++;
      end else if (busy_prev) begin
        chk("busy_len", 32'(busy_len), 32'(CAP_DLY + 1));
        cap_exp = grid_val(rise_cyc + CAP_DLY);
      end
      if (trig_b && !trig_b_prev) trig_b_seen++;
    end
    trig_prev = trig;
    busy_prev = busy;
    trig_b_prev = trig_b;
    dout_i = grid_val(cyc);
    cyc++;
  end

  task automatic spi_begin();
    @(posedge clk); #2;
    cs_n = 1'b0;
    #(HALF);
  endtask

  task automatic spi_bit(input logic b, output logic s);
    mosi = b;
    #(HALF); sck = 1'b1;
    #(HALF); s = miso; sck = 1'b0;
  endtask

  task automatic spi_end();
    #(HALF); cs_n = 1'b1; mosi = 1'b0;
    #(3*HALF);
  endtask

  task automatic spi_frame(input logic [63:0] bits, input int nb, output logic [63:0] smp);
    logic s;
    smp = 64'd0;
    spi_begin();
    for (int j = 0; j < nb; j++) begin
      spi_bit(bits[nb-1-j], s);
      smp[j] = s;
    end
    spi_end();
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_shadow"}, {7'd0, sign, bias, win, din}, {7'd0, sh_exp});
    chk({tag, "_shadow_b"}, {7'd0, sign_b, bias_b, win_b, din_b}, {7'd0, sh_exp});
    chk({tag, "_trigs"}, 32'(trig_seen), 32'(trig_exp));
    chk({tag, "_trigs_b"}, 32'(trig_b_seen), 32'(trig_b_exp));
    chk({tag, "_miso_idle"}, {31'd0, miso}, 32'd0);
  endtask

  task automatic do_write(input int len, input logic [63:0] pay);
    logic [63:0] bits, smp, mask;
    mask = (64'd1 << len) - 64'd1;
    bits = (64'h01 << len) | (pay & mask);
    spi_frame(bits, 8 + len, smp);
    if (len == PAY_W) sh_exp = pay[PAY_W-1:0];
    check_frame("write");
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || busy_b) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {30'd0, busy, busy_b}, 32'd0);
  endtask

  task automatic do_trig(input int extra);
    logic [63:0] smp;
    spi_frame((64'h02 << extra) | 64'(($urandom & 32'hF) & ((32'd1 << extra) - 32'd1)), 8 + extra, smp);
    trig_exp++;
    trig_b_exp++;
    wait_idle();
    check_frame("trig");
  endtask

  task automatic do_read();
    logic [63:0] smp, exp_v;
    exp_v = 64'd0;
    for (int j = 7; j < 15; j++) exp_v[j] = cap_exp[14-j];
    spi_frame(64'h03 << 12, 20, smp);
    chk("read_bits", smp[31:0], exp_v[31:0]);
    check_frame("read");
  endtask

  task automatic do_junk(input logic [7:0] c, input int nb);
    logic [63:0] smp;
    spi_frame({16'd0, c, {$urandom, $urandom}} >> (40 - nb), 8 + nb, smp);
    check_frame("junk");
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_kill = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out", {4'd0, sign, bias, win, din, trig, busy, miso}, 32'd0);
    chk("rst_out_b", {29'd0, trig_b, busy_b, miso_b}, 32'd0);
    sh_exp = 25'd0;
    cap_exp = 8'd0;
    @(negedge clk);
    mon_kill = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic s;
    int kind, k;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {4'd0, sign, bias, win, din, trig, busy, miso}, 32'd0);
    do_read();

    do_write(PAY_W, 64'h1A53C7F);
    chk("w1_sign", {31'd0, sign}, 32'd1);
    chk("w1_bias", {24'd0, bias}, 32'hA5);
    chk("w1_win", {24'd0, win}, 32'h3C);
    chk("w1_din", {24'd0, din}, 32'h7F);
    do_write(PAY_W - 1, {$urandom, $urandom});
    do_write(PAY_W + 1, {$urandom, $urandom});
    chk("w2_keep", {7'd0, sign, bias, win, din}, 32'h1A53C7F);

    do_trig(0);
    do_read();

    // Back-to-back TRIGs: the long-capture instance is still busy for the second.
    spi_frame(64'h02, 8, s);
    trig_exp++;
    trig_b_exp++;
    chk("b_busy", {31'd0, busy_b}, 32'd1);
    spi_frame(64'h02, 8, s);
    trig_exp++;
    wait_idle();
    check_frame("b2b");
    do_read();
    do_junk(8'hFF, 40);

    // Reset in the middle of a payload.
    spi_begin();
    for (int j = 0; j < 18; j++) spi_bit((j == 7) || (j > 8 && j[0]), s);
    do_reset();
    spi_end();
    check_frame("rst_pay");
    do_write(PAY_W, {$urandom, $urandom});

    // Reset while the trig pulse is high.
    spi_begin();
    for (int j = 0; j < 8; j++) spi_bit(j == 6, s);
    #(HALF); cs_n = 1'b1;
    k = 0;
    while (!trig && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("trig_seen_to", {31'd0, trig}, 32'd1);
    trig_exp++;
    trig_b_exp++;
    do_reset();
    repeat (30) @(negedge clk);
    check_frame("rst_trig");
    do_read();
    do_write(PAY_W, {$urandom, $urandom});

    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: do_write(($urandom_range(0, 1) == 0) ? PAY_W : $urandom_range(20, 30), {$urandom, $urandom});
        1: do_trig($urandom_range(0, 3));
        2: do_read();
        default: begin
          k = $urandom_range(4, 255);
          do_junk(8'(k), $urandom_range(0, 40));
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
